// File: rtl/freq_meter_ctrl.sv
// freq_meter_ctrl
//   Measurement sequencer for the digital frequency meter. It steps the shared
//   BCD decade-counter chain through clear -> count (gate) -> settle -> latch ->
//   hold, and repeats while run is high. It also reports the range and the
//   overflow status that belong to the latched result.
//
// Ports
//   clk        in   1  system clock
//   Rst_n      in   1  asynchronous active-low reset
//   run        in   1  level: continuous measurement while high
//   single     in   1  pulse: one measurement cycle, honoured only from IDLE
//   range_sel  in   2  gate range: 0 = GATE_CYCLES, 1 = /10, 2 and 3 = /100
//   ovf        in   1  carry out of the top decade, sampled during the gate
//   gate       out  1  count enable to the decade chain
//   cnt_clr    out  1  synchronous clear to the decade chain
//   latch      out  1  one-cycle strobe that loads the display registers
//   range_q    out  2  range of the latched result
//   ovf_flag   out  1  overflow seen during the latched measurement
//   busy       out  1  high in every state except IDLE
//
// All outputs are flops. Each one is written with the value that belongs to
// the state being entered, so no input reaches an output combinationally.

module freq_meter_ctrl #(
  parameter int GATE_CYCLES   = 50_000_000,  // >= 100, multiple of 100
  parameter int CLR_CYCLES    = 2,           // >= 1
  parameter int SETTLE_CYCLES = 4,           // >= 1
  parameter int HOLD_CYCLES   = 25_000_000   // >= 1
) (
  input  logic       clk,
  input  logic       Rst_n,
  input  logic       run,
  input  logic       single,
  input  logic [1:0] range_sel,
  input  logic       ovf,
  output logic       gate,
  output logic       cnt_clr,
  output logic       latch,
  output logic [1:0] range_q,
  output logic       ovf_flag,
  output logic       busy
);

  // The longest state sets the timer width. The timer is loaded with
  // length-1, so $clog2(length) bits are always enough.
  localparam int MAX_A  = (GATE_CYCLES > HOLD_CYCLES) ? GATE_CYCLES : HOLD_CYCLES;
  localparam int MAX_B  = (CLR_CYCLES > SETTLE_CYCLES) ? CLR_CYCLES : SETTLE_CYCLES;
  localparam int MAXLEN = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int TW     = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;

  localparam logic [TW-1:0] CLR_LD    = TW'(CLR_CYCLES - 1);
  localparam logic [TW-1:0] G0_LD     = TW'(GATE_CYCLES - 1);
  localparam logic [TW-1:0] G1_LD     = TW'(GATE_CYCLES / 10 - 1);
  localparam logic [TW-1:0] G2_LD     = TW'(GATE_CYCLES / 100 - 1);
  localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LD   = TW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    GATE   = 3'd2,
    SETTLE = 3'd3,
    LATCH  = 3'd4,
    HOLD   = 3'd5
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;       // down-counter; 0 is the last cycle of a state
  logic [1:0]    range_r;     // range used by the cycle in progress
  logic          ovf_sticky;  // any ovf seen during the current gate

  // range_r is stored normalised, so range 3 behaves as range 2 everywhere
  // and is also reported as 2 for decimal-point placement.
  function automatic logic [1:0] norm_range(input logic [1:0] r);
    return (r == 2'd3) ? 2'd2 : r;
  endfunction

  function automatic logic [TW-1:0] gate_ld(input logic [1:0] r);
    case (r)
      2'd0:    return G0_LD;
      2'd1:    return G1_LD;
      default: return G2_LD;
    endcase
  endfunction

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= IDLE;
      timer      <= '0;
      range_r    <= 2'd0;
      ovf_sticky <= 1'b0;
      gate       <= 1'b0;
      cnt_clr    <= 1'b0;
      latch      <= 1'b0;
      range_q    <= 2'd0;
      ovf_flag   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (run || single) begin
            state      <= CLEAR;
            timer      <= CLR_LD;
            range_r    <= norm_range(range_sel);
            ovf_sticky <= 1'b0;
            cnt_clr    <= 1'b1;
            busy       <= 1'b1;
          end
        end

        CLEAR: begin
          if (timer == '0) begin
            state   <= GATE;
            timer   <= gate_ld(range_r);
            cnt_clr <= 1'b0;
            gate    <= 1'b1;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        GATE: begin
          if (ovf) ovf_sticky <= 1'b1;
          if (timer == '0) begin
            state <= SETTLE;
            timer <= SETTLE_LD;
            gate  <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        // Gives the ripple through the decade chain time to settle
        // before the display registers are loaded.
        SETTLE: begin
          if (timer == '0) begin
            state <= LATCH;
            timer <= '0;
            latch <= 1'b1;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        // Range and overflow become visible together with the newly
        // latched display value.
        LATCH: begin
          state    <= HOLD;
          timer    <= HOLD_LD;
          latch    <= 1'b0;
          range_q  <= range_r;
          ovf_flag <= ovf_sticky;
        end

        HOLD: begin
          if (timer == '0) begin
            if (run) begin
              state      <= CLEAR;
              timer      <= CLR_LD;
              range_r    <= norm_range(range_sel);
              ovf_sticky <= 1'b0;
              cnt_clr    <= 1'b1;
            end else begin
              state <= IDLE;
              timer <= '0;
              busy  <= 1'b0;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          timer   <= '0;
          gate    <= 1'b0;
          cnt_clr <= 1'b0;
          latch   <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
